// File: rtl/tank_shell_if.sv
// Bundle between the tank/keyboard side and the shell controller.
// The master drives the tank state and the key; the slave returns the shell sprite state.
interface tank_shell_if;
   logic [15:0] keycode;
   logic [9:0]  TankX;
   logic [9:0]  TankY;
   logic [2:0]  Direction;
   logic        hit;
   logic [9:0]  ShellX;
   logic [9:0]  ShellY;
   logic [2:0]  ShellDir;
   logic        ShellActive;
   logic        Exploding;
   logic        Fired;

   modport master (
      output keycode, TankX, TankY, Direction, hit,
      input  ShellX, ShellY, ShellDir, ShellActive, Exploding, Fired
   );

   modport slave (
      input  keycode, TankX, TankY, Direction, hit,
      output ShellX, ShellY, ShellDir, ShellActive, Exploding, Fired
   );
endinterface

// File: rtl/tank_shell.sv
// Shell controller: launches one shell per trigger, flies it per frame, explodes, cools down.
// Optional TANK_SHELL_AUTOFIRE_EN: a held fire key re-launches without a release.
module tank_shell #(
   parameter int          X_MAX           = 639,
   parameter int          Y_MAX           = 479,
   parameter int          TANK_HALF       = 32,
   parameter int          SHELL_SIZE      = 4,
   parameter int          SHELL_STEP      = 8,
   parameter int          EXPLODE_FRAMES  = 8,
   parameter int          COOLDOWN_FRAMES = 15,
   parameter logic [7:0]  FIRE_KEY        = 8'h2C
) (
   input  logic         frame_clk,
   input  logic         Reset,
   tank_shell_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, FLY, BOOM, COOL} state_t;

   localparam logic signed [10:0] HALF     = 11'(TANK_HALF);
   localparam logic signed [10:0] STEP     = 11'(SHELL_STEP);
   localparam logic signed [10:0] LO       = 11'(SHELL_SIZE);
   localparam logic signed [10:0] HI_X     = 11'(X_MAX - SHELL_SIZE);
   localparam logic signed [10:0] HI_Y     = 11'(Y_MAX - SHELL_SIZE);
   localparam logic [4:0]         EXP_LOAD = 5'(EXPLODE_FRAMES - 1);
   localparam logic [4:0]         CD_LOAD  = 5'(COOLDOWN_FRAMES - 1);

   // Negative values (underflow) fall below LO, so they are rejected too.
   function automatic logic legal(input logic signed [10:0] c, input logic signed [10:0] hi);
      return (c >= LO) && (c <= hi);
   endfunction

   state_t                state, state_nxt;
   logic [4:0]            cnt, cnt_nxt;
   logic [9:0]            shell_x, shell_y, x_nxt, y_nxt;
   logic [2:0]            dir, dir_nxt;
   logic                  fired, fired_nxt;
   logic                  fire_held;
   logic                  pressed, fire_go;
   logic signed [10:0]    tx, ty, mx, my, sx, sy, nx, ny;

   assign pressed = (bus.keycode[7:0] == FIRE_KEY) || (bus.keycode[15:8] == FIRE_KEY);

`ifdef TANK_SHELL_AUTOFIRE_EN
   assign fire_go = pressed;
`else
   assign fire_go = pressed && !fire_held;
`endif

   assign tx = signed'({1'b0, bus.TankX});
   assign ty = signed'({1'b0, bus.TankY});
   assign sx = signed'({1'b0, shell_x});
   assign sy = signed'({1'b0, shell_y});

   always_comb begin
      mx = tx;
      my = ty;
      nx = sx;
      ny = sy;
      unique case (bus.Direction[2:1])
         2'b00:   my = ty - HALF;
         2'b01:   my = ty + HALF;
         2'b10:   mx = tx - HALF;
         default: mx = tx + HALF;
      endcase
      unique case (dir[2:1])
         2'b00:   ny = sy - STEP;
         2'b01:   ny = sy + STEP;
         2'b10:   nx = sx - STEP;
         default: nx = sx + STEP;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      x_nxt     = shell_x;
      y_nxt     = shell_y;
      dir_nxt   = dir;
      fired_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            // An edge with an illegal muzzle is simply dropped.
            if (fire_go && legal(mx, HI_X) && legal(my, HI_Y)) begin
               x_nxt     = mx[9:0];
               y_nxt     = my[9:0];
               dir_nxt   = bus.Direction;
               fired_nxt = 1'b1;
               state_nxt = FLY;
            end
         end
         FLY: begin
            if (bus.hit || !legal(nx, HI_X) || !legal(ny, HI_Y)) begin
               state_nxt = BOOM;
               cnt_nxt   = EXP_LOAD;
            end else begin
               x_nxt = nx[9:0];
               y_nxt = ny[9:0];
            end
         end
         BOOM: begin
            if (cnt == 5'd0) begin
               state_nxt = COOL;
               cnt_nxt   = CD_LOAD;
            end else begin
               cnt_nxt = cnt - 5'd1;
            end
         end
         default: begin
            if (cnt == 5'd0) state_nxt = IDLE;
            else             cnt_nxt   = cnt - 5'd1;
         end
      endcase
   end

   // fire_held resets high so a key held through reset cannot fire.
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state     <= IDLE;
         cnt       <= 5'd0;
         shell_x   <= 10'd0;
         shell_y   <= 10'd0;
         dir       <= 3'd0;
         fired     <= 1'b0;
         fire_held <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         shell_x   <= x_nxt;
         shell_y   <= y_nxt;
         dir       <= dir_nxt;
         fired     <= fired_nxt;
         fire_held <= pressed;
      end
   end

   assign bus.ShellX      = shell_x;
   assign bus.ShellY      = shell_y;
   assign bus.ShellDir    = dir;
   assign bus.ShellActive = (state == FLY);
   assign bus.Exploding   = (state == BOOM);
   assign bus.Fired       = fired;

endmodule

// File: tb/tb_tank_shell.sv
// Directed bench for tank_shell: table-driven launch vectors plus hand-written corner sequences.
module tb_tank_shell;

   logic frame_clk = 1'b0;
   logic Reset;
   int   tests = 0;
   int   fails = 0;

   tank_shell_if bus ();

   tank_shell dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .bus       (bus)
   );

   always #5 frame_clk = ~frame_clk;

   typedef struct {
      logic [15:0] key;
      logic [9:0]  tx;
      logic [9:0]  ty;
      logic [2:0]  dir;
      logic        hit;
      int          ex;
      int          ey;
      int          ea;
      int          ee;
      int          ef;
   } vec_t;

   vec_t vt [4];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input int ex, input int ey, input int ea,
                          input int ee, input int ef);
      chk({tag, ".x"},     int'(bus.ShellX),      ex);
      chk({tag, ".y"},     int'(bus.ShellY),      ey);
      chk({tag, ".act"},   int'(bus.ShellActive), ea);
      chk({tag, ".expl"},  int'(bus.Exploding),   ee);
      chk({tag, ".fired"}, int'(bus.Fired),       ef);
   endtask

   initial begin
      int fired_cnt;
      int exp_cnt;

      vt[0] = '{16'h002C, 10'd320, 10'd240, 3'b000, 1'b0, 320, 208, 1, 0, 1};
      vt[1] = '{16'h0000, 10'd320, 10'd240, 3'b000, 1'b0, 320, 200, 1, 0, 0};
      vt[2] = '{16'h0000, 10'd50,  10'd400, 3'b110, 1'b0, 320, 192, 1, 0, 0};
      vt[3] = '{16'h002C, 10'd320, 10'd240, 3'b000, 1'b0, 320, 184, 1, 0, 0};

      Reset         = 1'b1;
      bus.keycode   = 16'h0;
      bus.TankX     = 10'd320;
      bus.TankY     = 10'd240;
      bus.Direction = 3'b000;
      bus.hit       = 1'b0;
      step();
      step();
      chk_all("reset", 0, 0, 0, 0, 0);
      chk("reset.dir", int'(bus.ShellDir), 0);
      Reset = 1'b0;
      step();

      for (int i = 0; i < 4; i++) begin
         bus.keycode   = vt[i].key;
         bus.TankX     = vt[i].tx;
         bus.TankY     = vt[i].ty;
         bus.Direction = vt[i].dir;
         bus.hit       = vt[i].hit;
         step();
         chk_all($sformatf("vec%0d", i), vt[i].ex, vt[i].ey, vt[i].ea, vt[i].ee, vt[i].ef);
      end
      chk("up.dir", int'(bus.ShellDir), 0);
      bus.keycode = 16'h0;

      for (int k = 4; k <= 25; k++) begin
         step();
         chk($sformatf("up.y%0d", k), int'(bus.ShellY), 208 - 8 * k);
         chk($sformatf("up.act%0d", k), int'(bus.ShellActive), 1);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         chk_all($sformatf("boom%0d", i), 320, 8, 0, 1, 0);
      end
      for (int i = 0; i < 15; i++) begin
         if (i == 5) bus.keycode = 16'h002C;
         step();
         bus.keycode = 16'h0;
         chk_all($sformatf("cool%0d", i), 320, 8, 0, 0, 0);
      end
      step();
      chk_all("idle", 320, 8, 0, 0, 0);

      bus.TankY   = 10'd20;
      bus.keycode = 16'h002C;
      step();
      chk_all("underflow", 320, 8, 0, 0, 0);
      bus.keycode = 16'h0;
      step();

      bus.Direction = 3'b110;
      bus.TankX     = 10'd100;
      bus.TankY     = 10'd240;
      bus.keycode   = 16'h2C00;
      step();
      chk_all("right.launch", 132, 240, 1, 0, 1);
      chk("right.dir", int'(bus.ShellDir), 6);
      bus.keycode = 16'h0;
      step();
      chk("right.x1", int'(bus.ShellX), 140);
      step();
      chk("right.x2", int'(bus.ShellX), 148);
      bus.hit = 1'b1;
      step();
      bus.hit = 1'b0;
      chk_all("right.hit", 148, 240, 0, 1, 0);
      for (int i = 0; i < 23; i++) step();
      chk_all("right.idle", 148, 240, 0, 0, 0);

      bus.TankX     = 10'd320;
      bus.TankY     = 10'd240;
      bus.Direction = 3'b000;
      bus.keycode   = 16'h002C;
      fired_cnt     = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (bus.Fired) fired_cnt++;
      end
`ifdef TANK_SHELL_AUTOFIRE_EN
      exp_cnt = 2;
`else
      exp_cnt = 1;
`endif
      chk("held.fired_count", fired_cnt, exp_cnt);

`ifndef TANK_SHELL_AUTOFIRE_EN
      bus.keycode = 16'h0;
      step();
      chk("release.fired", int'(bus.Fired), 0);
      bus.keycode = 16'h002C;
      step();
      chk_all("second", 320, 208, 1, 0, 1);
      step();
      chk_all("second.fly", 320, 200, 1, 0, 0);

      Reset = 1'b1;
      step();
      chk_all("midreset", 0, 0, 0, 0, 0);
      chk("midreset.dir", int'(bus.ShellDir), 0);
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all($sformatf("heldreset%0d", i), 0, 0, 0, 0, 0);
      end
      bus.keycode = 16'h0;
      step();
      bus.keycode = 16'h002C;
      step();
      chk_all("repress", 320, 208, 1, 0, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
